// File: rtl/cp0_unit_if.sv
// cp0_unit_if: pipeline <-> coprocessor-0 signal bundle.
// master = pipeline side (issues mfc0/mtc0, victim info, eret retire)
// slave  = cp0_unit (returns read data, EPC and the Req pulse)
interface cp0_unit_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        we;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    modport master (
        output A1, A2, DIn, we, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  DOut, EPCOut, Req
    );

    modport slave (
        input  A1, A2, DIn, we, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output DOut, EPCOut, Req
    );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 (SR, Cause, EPC, PRId).
// Arbitrates level interrupts and synchronous exceptions into Req and
// provides the eret return address on EPCOut.
// Optional macro CP0_EPC_BYPASS_EN: forward an in-flight mtc0 EPC value
// straight to EPCOut so eret right behind it needs no stall.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic       clk,
    input  logic       rst_n,
    cp0_unit_if.slave  bus
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_vpc_adj;
    logic [31:0] w_dout;
    logic [31:0] w_epc_out;

    // Request arbitration: nothing is taken while a handler is running (EXL=1).
    always_comb begin
        w_int_req = r_ie & ~r_exl & (|(bus.HWInt & r_im));
        w_exc_req = ~r_exl & (bus.ExcCodeIn != 5'd0);
        w_req     = w_int_req | w_exc_req;
        // A victim in a delay slot returns to its branch, one word earlier.
        if (bus.BDIn) begin
            w_vpc_adj = bus.VPC - 32'd4;
        end else begin
            w_vpc_adj = bus.VPC;
        end
    end

    // CP0 state update: exception entry, mtc0 writes, eret clear, IP sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_req) begin
                // Exception entry; blocks mtc0 and eret in the same cycle.
                r_exl     <= 1'b1;
                r_bd      <= bus.BDIn;
                r_exccode <= w_int_req ? 5'd0 : bus.ExcCodeIn;
                r_epc     <= {w_vpc_adj[31:2], 2'b00};
            end else begin
                if (bus.we) begin
                    case (bus.A2)
                        REG_SR: begin
                            r_im  <= bus.DIn[15:10];
                            r_exl <= bus.DIn[1];
                            r_ie  <= bus.DIn[0];
                        end
                        REG_EPC: begin
                            r_epc <= {bus.DIn[31:2], 2'b00};
                        end
                        default: begin
                            // Cause, PRId and unmapped numbers are not writable.
                        end
                    endcase
                end
                // eret wins over an mtc0 SR for the EXL bit (last assignment).
                if (bus.EXLClr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux over registered state; unmapped numbers read zero.
    always_comb begin
        w_dout = 32'd0;
        case (bus.A1)
            REG_SR:    w_dout = {16'd0, r_im, 8'd0, r_exl, r_ie};
            REG_CAUSE: w_dout = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
            REG_EPC:   w_dout = r_epc;
            REG_PRID:  w_dout = PRID;
            default:   w_dout = 32'd0;
        endcase
    end

    // eret return address, optionally forwarding a same-cycle mtc0 EPC.
    always_comb begin
`ifdef CP0_EPC_BYPASS_EN
        if (bus.we && (bus.A2 == REG_EPC) && !w_req) begin
            w_epc_out = {bus.DIn[31:2], 2'b00};
        end else begin
            w_epc_out = r_epc;
        end
`else
        w_epc_out = r_epc;
`endif
    end

    assign bus.Req    = w_req;
    assign bus.DOut   = w_dout;
    assign bus.EPCOut = w_epc_out;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: scoreboard bench for cp0_unit. Expected values are queued
// as stimulus is applied and compared when outputs are sampled mid-cycle.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h4D49_5053;
    localparam int SEL_DOUT = 0;
    localparam int SEL_EPC  = 1;
    localparam int SEL_REQ  = 2;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    cp0_unit_if bus ();

    cp0_unit #(.PRID(PRID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued.
    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_DOUT: obs = bus.DOut;
                SEL_EPC:  obs = bus.EPCOut;
                default:  obs = {31'd0, bus.Req};
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        bus.A1 = a;
        push_exp(tag, SEL_DOUT, exp);
        drain();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] epc_byp;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.we = 1'b0;
        bus.VPC = 32'd0; bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0;
        bus.HWInt = 6'd0; bus.EXLClr = 1'b0;

        // Reset state
        #2;
        push_exp("rst_req", SEL_REQ, 32'd0);
        push_exp("rst_epcout", SEL_EPC, 32'd0);
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd15, "rst_prid", PRID);
        #10 rst_n = 1'b1;

        // C1: mtc0 SR, same-cycle read returns old value
        next_cycle();
        bus.we = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC01;
        rd(5'd12, "sr_old", 32'd0);

        // C2: new SR visible, PRId, Cause
        next_cycle();
        bus.we = 1'b0;
        rd(5'd12, "sr_new", 32'h0000_FC01);
        rd(5'd15, "prid", PRID);
        rd(5'd13, "cause_idle", 32'd0);
        push_exp("req_idle", SEL_REQ, 32'd0);
        drain();

        // C3: interrupt
        next_cycle();
        bus.HWInt = 6'b000100; bus.VPC = 32'h0000_3010; bus.BDIn = 1'b0;
        push_exp("int_req", SEL_REQ, 32'd1);
        drain();

        // C4: handler entered
        next_cycle();
        push_exp("int_nonest", SEL_REQ, 32'd0);
        push_exp("int_epcout", SEL_EPC, 32'h0000_3010);
        rd(5'd14, "int_epc", 32'h0000_3010);
        rd(5'd13, "int_cause", 32'h0000_1000);
        rd(5'd12, "int_sr", 32'h0000_FC03);
        bus.HWInt = 6'd0; bus.EXLClr = 1'b1;

        // C5: EXL cleared; exception in delay slot
        next_cycle();
        bus.EXLClr = 1'b0;
        rd(5'd12, "eret_sr", 32'h0000_FC01);
        bus.ExcCodeIn = 5'd4; bus.BDIn = 1'b1; bus.VPC = 32'h0000_3024;
        push_exp("exc_req", SEL_REQ, 32'd1);
        drain();

        // C6: exception state
        next_cycle();
        bus.ExcCodeIn = 5'd0; bus.BDIn = 1'b0;
        rd(5'd14, "exc_epc", 32'h0000_3020);
        rd(5'd13, "exc_cause", 32'h8000_0010);
        bus.EXLClr = 1'b1;

        // C7: interrupt + exception + mtc0 EPC together
        next_cycle();
        bus.EXLClr = 1'b0;
        bus.HWInt = 6'b000100; bus.ExcCodeIn = 5'd10; bus.VPC = 32'h0000_3100;
        bus.we = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3400;
        push_exp("both_req", SEL_REQ, 32'd1);
        push_exp("both_epcout_nobyp", SEL_EPC, 32'h0000_3020);
        drain();

        // C8: interrupt won, mtc0 dropped
        next_cycle();
        bus.ExcCodeIn = 5'd0; bus.we = 1'b0;
        rd(5'd13, "both_cause", 32'h0000_1000);
        rd(5'd14, "drop_epc", 32'h0000_3100);
        push_exp("both_nonest", SEL_REQ, 32'd0);
        drain();
        bus.EXLClr = 1'b1;

        // C9: pending interrupt re-asserts after eret
        next_cycle();
        bus.EXLClr = 1'b0; bus.VPC = 32'h0000_3200;
        push_exp("reint_req", SEL_REQ, 32'd1);
        drain();

        // C10: mtc0 EPC without Req
        next_cycle();
        bus.we = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3403;
`ifdef CP0_EPC_BYPASS_EN
        epc_byp = 32'h0000_3400;
`else
        epc_byp = 32'h0000_3200;
`endif
        push_exp("mtc0_epcout", SEL_EPC, epc_byp);
        push_exp("mtc0_req", SEL_REQ, 32'd0);
        rd(5'd14, "mtc0_epc_old", 32'h0000_3200);

        // C11: EPC written; write to Cause attempted
        next_cycle();
        bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
        push_exp("epc_next_out", SEL_EPC, 32'h0000_3400);
        rd(5'd14, "epc_next", 32'h0000_3400);

        // C12: Cause unchanged; mtc0 SR with eret at the same edge
        next_cycle();
        rd(5'd13, "cause_ro", 32'h0000_1000);
        bus.HWInt = 6'd0;
        bus.A2 = 5'd12; bus.DIn = 32'h0000_FC03; bus.EXLClr = 1'b1;

        // C13: EXLClr beat SR.EXL; unmapped read; then exception
        next_cycle();
        bus.we = 1'b0; bus.EXLClr = 1'b0;
        rd(5'd12, "sr_exlclr", 32'h0000_FC01);
        rd(5'd5, "unmapped", 32'd0);
        bus.ExcCodeIn = 5'd8; bus.VPC = 32'h0000_3500;
        push_exp("exc2_req", SEL_REQ, 32'd1);
        drain();

        // C14: reset mid-handler, no clock edge needed
        next_cycle();
        bus.ExcCodeIn = 5'd0;
        rd(5'd12, "pre_rst_sr", 32'h0000_FC03);
        rst_n = 1'b0;
        rd(5'd12, "mid_rst_sr", 32'd0);
        rd(5'd13, "mid_rst_cause", 32'd0);
        push_exp("mid_rst_epcout", SEL_EPC, 32'd0);
        rd(5'd14, "mid_rst_epc", 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block for the pipelined MIPS core: holds SR, Cause, EPC and PRId, arbitrates interrupts and exceptions into a single `Req` pulse, and supplies `EPCOut` to the next-PC logic for `eret` return. It is the producer end of the `Req` / `EPCOut` / `EXLClr` interface that the next-PC selector consumes. It sits beside the MEM stage; all state changes on the rising clock edge.

## Interface
- `PRID`, 32'h4D49_5053, value returned for reads of register 15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A1`  in  5  mfc0 read register number.
- `A2`  in  5  mtc0 write register number.
- `DIn`  in  32  mtc0 write data.
- `we`  in  1  mtc0 write enable.
- `VPC`  in  32  PC of the MEM-stage (victim) instruction, absolute address.
- `BDIn`  in  1  victim instruction is in a branch delay slot.
- `ExcCodeIn`  in  5  synchronous exception code; 0 = none.
- `HWInt`  in  6  external interrupt lines, level sensitive.
- `EXLClr`  in  1  eret retiring in MEM; clears EXL.
- `DOut`  out  32  mfc0 read data.
- `EPCOut`  out  32  exception return address, absolute.
- `Req`  out  1  take exception/interrupt this cycle; flushes pipe, redirects PC to handler.

## Operation
- Registers: SR (12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause (13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC (14) full 32 bits; PRId (15) = `PRID`, read-only. Unlisted bits read 0.
- `IntReq = IE & ~EXL & |(HWInt & IM)`; `ExcReq = ~EXL & (ExcCodeIn != 0)`; `Req = IntReq | ExcReq` (combinational).
- On edge with `Req`: EXL←1; BD←`BDIn`; ExcCode←0 if `IntReq` else `ExcCodeIn` (interrupt wins over simultaneous exception); EPC←(`BDIn` ? `VPC`−4 : `VPC`) with bits [1:0] forced to 0.
- On edge without `Req`: `we` writes SR (IM, EXL, IE fields only) for A2=12, EPC (bits [1:0] forced 0) for A2=14; writes to 13, 15 and any other number are ignored. `EXLClr` clears EXL; if `we` to SR in the same cycle, `EXLClr` takes precedence for the EXL bit.
- `Req` blocks `we` and `EXLClr` in that cycle.
- IP←`HWInt` every edge, regardless of `Req`.
- `DOut`: combinational read of A1 from registered state; unmapped → 0.
- While EXL=1, `Req` stays 0 (no nesting).

## Timing
- Reset (`rst_n`=0, asynchronous): SR=0, Cause=0, EPC=0; hence `Req`=0, `DOut`=0 (or `PRID` if A1=15), `EPCOut`=0.
- `Req`: zero latency from inputs; register effects visible the cycle after.
- mtc0 → mfc0 of same register: new value visible one cycle after the write edge; same-cycle read returns old value.
- `EXLClr` at edge N: `Req` may assert in cycle N+1.
- Reset asserted mid-handler (EXL=1) returns everything to reset values immediately.

## Configuration
- `CP0_EPC_BYPASS_EN` defined: `EPCOut` = `DIn` (bits [1:0] zeroed) when `we` & A2=14 & ~`Req`, else EPC — so an mtc0 EPC immediately followed by eret returns to the new address without a stall.
- Undefined: `EPCOut` = EPC register only; the hazard unit stalls eret behind mtc0 EPC.

## Test plan
- Reset, then mtc0 SR=32'h0000_FC01, mfc0 12 next cycle → `DOut`=32'h0000_FC01; mfc0 15 → 32'h4D49_5053.
- IE=1, IM=6'h3F, `HWInt`=6'b000100, `VPC`=32'h0000_3010, `BDIn`=0 → `Req`=1 same cycle; next cycle EPC=32'h0000_3010, ExcCode=0, EXL=1, `Req`=0 with `HWInt` still high.
- `ExcCodeIn`=5'd4, `BDIn`=1, `VPC`=32'h0000_3024 → `Req`=1; then EPC=32'h0000_3020, BD=1, ExcCode=4; Cause reads 32'h8000_0010.
- Interrupt and `ExcCodeIn`=5'd10 same cycle → ExcCode=0; `EXLClr` next cycle → EXL=0, pending interrupt re-asserts `Req` the following cycle.
- mtc0 EPC=32'h0000_3400 with `Req` high → write dropped; without `Req`, with `CP0_EPC_BYPASS_EN` → `EPCOut`=32'h0000_3400 same cycle; without macro → next cycle.
- Pull `rst_n` low mid-cycle with EXL=1 → SR, Cause, EPC zero immediately, no clock edge required.
